// File: rtl/add_serial_sched.sv
// -----------------------------------------------------------------------------
// add_serial_sched
//
// Round-robin scheduler that shares one bit-serial adder among N_REQ
// requesters. It handles one operation at a time:
//   IDLE  : picks a requester, latches its operands and its index.
//   ISSUE : pulses gnt and add_en for one cycle.
//   WAIT  : waits for add_done, then captures add_sum.
//   RESP  : presents the result on a valid/ready port.
// Every output is a register or is decoded from the state register only.
//
// Optional watchdog: define ADD_SERIAL_SCHED_WATCHDOG_EN. A WAIT with no
// add_done for TIMEOUT cycles then ends in RESP with rsp_sum=0, rsp_err=1.
// With the macro undefined, WAIT has no time limit and rsp_err is always 0.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   req[N_REQ]        level request per requester, held until gnt
//   a_in, b_in        packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt[N_REQ]        one-hot acceptance pulse, high during ISSUE
//   add_en            adder start pulse, high during ISSUE
//   add_a, add_b      latched operands driven to the adder
//   add_done, add_sum adder completion strobe and result
//   rsp_valid/ready   response handshake
//   rsp_id/sum/err    index of the response, its sum, watchdog abort flag
//   busy              high in every state except IDLE
// -----------------------------------------------------------------------------
module add_serial_sched #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     a_in,
  input  logic [N_REQ*WIDTH-1:0]     b_in,
  output logic [N_REQ-1:0]           gnt,
  output logic                       add_en,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  input  logic                       add_done,
  input  logic [WIDTH-1:0]           add_sum,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;

`ifdef ADD_SERIAL_SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           rsp_err_q, rsp_err_d;
`endif

  // Round-robin pick: scan from the farthest offset back to ptr so the
  // requester closest to ptr (in wrap order) is the one left standing.
  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] scan_idx;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_idx = IDW'((int'(ptr_q) + i) % N_REQ);
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rsp_id_d  = rsp_id_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    rsp_sum_d = rsp_sum_q;
`ifdef ADD_SERIAL_SCHED_WATCHDOG_EN
    wd_cnt_d  = wd_cnt_q;
    rsp_err_d = rsp_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          add_a_d  = a_in[pick_idx*WIDTH +: WIDTH];
          add_b_d  = b_in[pick_idx*WIDTH +: WIDTH];
          rsp_id_d = pick_idx;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ADD_SERIAL_SCHED_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        // A done strobe on the last allowed cycle beats the watchdog.
        if (add_done) begin
          rsp_sum_d = add_sum;
          state_d   = S_RESP;
`ifdef ADD_SERIAL_SCHED_WATCHDOG_EN
          rsp_err_d = 1'b0;
        end else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
          rsp_sum_d = '0;
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          ptr_d   = (rsp_id_q == IDW'(N_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: operand and result registers are reset along with the control
    // state, since every output must read 0 while rst is asserted.
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      rsp_id_q  <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      rsp_sum_q <= '0;
`ifdef ADD_SERIAL_SCHED_WATCHDOG_EN
      wd_cnt_q  <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the values from before this edge, whatever the order.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rsp_id_q  <= rsp_id_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      rsp_sum_q <= rsp_sum_d;
`ifdef ADD_SERIAL_SCHED_WATCHDOG_EN
      wd_cnt_q  <= wd_cnt_d;
      rsp_err_q <= rsp_err_d;
`endif
    end
  end

  // Outputs: registers or decodes of state_q only.
  assign gnt       = (state_q == S_ISSUE) ? (N_REQ'(1) << rsp_id_q) : '0;
  assign add_en    = (state_q == S_ISSUE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
`ifdef ADD_SERIAL_SCHED_WATCHDOG_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_add_serial_sched.sv
// -----------------------------------------------------------------------------
// tb_add_serial_sched
//
// Self-checking bench for add_serial_sched. A behavioural model holds the
// requester operands, the request mask and the round-robin pointer; the
// expected winner and sum come from those with plain arithmetic. A small
// adder model answers add_en after a chosen latency. The watchdog scenarios
// are compiled only when ADD_SERIAL_SCHED_WATCHDOG_EN is defined.
// -----------------------------------------------------------------------------
module tb_add_serial_sched;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TO  = 15;
  localparam int IDW = $clog2(N);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in, b_in;
  logic [N-1:0]     gnt;
  logic             add_en;
  logic [W-1:0]     add_a, add_b;
  logic             add_done;
  logic [W-1:0]     add_sum;
  logic             rsp_valid, rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_sum;
  logic             rsp_err;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] a_m [N];
  logic [W-1:0] b_m [N];
  logic [N-1:0] req_m;
  int           ptr_m;

  add_serial_sched #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_done  (add_done),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    req = req_m;
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = a_m[i];
      b_in[i*W +: W] = b_m[i];
    end
  endtask

  // First requesting index found walking ptr, ptr+1, ... modulo N.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] model_sum(input int id);
    int s;
    s = (int'(a_m[id]) + int'(b_m[id])) % (1 << W);
    return W'(s);
  endfunction

  // One full transaction from IDLE (request already driven) back to IDLE.
  // lat: WAIT cycle on which add_done is given; stall: cycles rsp_ready is
  // held low in RESP; drop: requester releases req once granted.
  task automatic do_txn(input string name, input int lat, input int stall, input bit drop);
    int           id;
    logic [N-1:0] eg;
    logic [W-1:0] es;
    id = rr_pick(req_m, ptr_m);
    checks++;
    if (id < 0) begin
      errors++;
      $display("FAIL %s: model has no pending request (got none, need one)", name);
      return;
    end
    eg = '0;
    eg[id] = 1'b1;
    es = model_sum(id);

    tick();  // ISSUE
    checks++;
    if ({gnt, add_en, busy, rsp_valid} !== {eg, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s issue: gnt=%b add_en=%b busy=%b rsp_valid=%b, need gnt=%b add_en=1 busy=1 rsp_valid=0",
               name, gnt, add_en, busy, rsp_valid, eg);
    end
    checks++;
    if ({add_a, add_b} !== {a_m[id], b_m[id]}) begin
      errors++;
      $display("FAIL %s operands: add_a=%h add_b=%h, need %h %h", name, add_a, add_b, a_m[id], b_m[id]);
    end
    if (drop) begin
      req_m[id] = 1'b0;
      drive();
    end

    tick();  // WAIT cycle 1
    checks++;
    if ({gnt, add_en, busy, rsp_valid} !== {{N{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s wait: gnt=%b add_en=%b busy=%b rsp_valid=%b, need 0 0 1 0",
               name, gnt, add_en, busy, rsp_valid);
    end
    for (int j = 1; j < lat; j++) tick();
    add_done = 1'b1;
    add_sum  = add_a + add_b;  // adder model works on what it is given
    tick();  // RESP
    add_done = 1'b0;
    add_sum  = W'($urandom);
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_err, busy} !== {1'b1, IDW'(id), es, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s resp: valid=%b id=%0d sum=%h err=%b busy=%b, need 1 %0d %h 0 1",
               name, rsp_valid, rsp_id, rsp_sum, rsp_err, busy, id, es);
    end

    // Stall: response must hold; stray add_done strobes must be ignored.
    for (int j = 0; j < stall; j++) begin
      add_done = 1'($urandom);
      add_sum  = W'($urandom);
      tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_err, gnt} !== {1'b1, IDW'(id), es, 1'b0, {N{1'b0}}}) begin
        errors++;
        $display("FAIL %s stall%0d: valid=%b id=%0d sum=%h err=%b gnt=%b, need 1 %0d %h 0 0",
                 name, j, rsp_valid, rsp_id, rsp_sum, rsp_err, gnt, id, es);
      end
    end
    add_done  = 1'b0;
    rsp_ready = 1'b1;
    tick();  // handshake edge
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, busy, gnt} !== {1'b0, 1'b0, {N{1'b0}}}) begin
      errors++;
      $display("FAIL %s handshake: rsp_valid=%b busy=%b gnt=%b, need 0 0 0", name, rsp_valid, busy, gnt);
    end
    ptr_m = (id + 1) % N;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, add_en, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset: gnt=%b add_en=%b add_a=%h add_b=%h valid=%b id=%0d sum=%h err=%b busy=%b, need all 0",
               gnt, add_en, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_err, busy);
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    ptr_m = 0;
    tick();
    checks++;
    if ({busy, gnt, rsp_valid} !== '0) begin
      errors++;
      $display("FAIL idle_no_req: busy=%b gnt=%b rsp_valid=%b, need 0", busy, gnt, rsp_valid);
    end
  endtask

  task automatic test_single();
    a_m[2] = 8'h35;
    b_m[2] = 8'h0A;
    req_m  = 4'b0100;
    drive();
    do_txn("single", 9, 0, 1'b1);
  endtask

  task automatic test_fairness();
    for (int i = 0; i < N; i++) begin
      a_m[i] = W'($urandom);
      b_m[i] = W'($urandom);
    end
    req_m = 4'b1111;
    drive();
    for (int k = 0; k < 6; k++) do_txn("fair", 1 + (k % 3), 0, 1'b0);
    req_m = '0;
    drive();
  endtask

  task automatic test_wrap();
    a_m[0] = 8'hFF;
    b_m[0] = 8'h01;
    req_m  = 4'b0001;
    drive();
    do_txn("wrap", 2, 0, 1'b1);
  endtask

  // req[1] stays pending through a 5-cycle stall; the follow-up grant must
  // only appear on the edge after the handshake.
  task automatic test_backpressure();
    req_m = 4'b0010;
    a_m[1] = W'($urandom);
    b_m[1] = W'($urandom);
    drive();
    do_txn("backpressure", 3, 5, 1'b0);
    do_txn("bp_next", 2, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        a_m[i] = W'($urandom);
        b_m[i] = W'($urandom);
      end
      req_m = req_m | N'($urandom_range(1, (1 << N) - 1));
      drive();
      do_txn("random", $urandom_range(1, 12), $urandom_range(0, 3), 1'($urandom));
    end
    req_m = '0;
    drive();
  endtask

  task automatic test_reset_mid_wait();
    req_m  = 4'b0100;
    a_m[2] = W'($urandom);
    b_m[2] = W'($urandom);
    drive();
    tick();  // ISSUE
    req_m = '0;
    drive();
    tick();  // WAIT
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, add_en, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: gnt=%b add_en=%b add_a=%h add_b=%h valid=%b id=%0d sum=%h err=%b busy=%b, need all 0",
               gnt, add_en, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_err, busy);
    end
    req_m = 4'b1010;
    for (int i = 0; i < N; i++) begin
      a_m[i] = W'($urandom);
      b_m[i] = W'($urandom);
    end
    drive();
    rst = 1'b0;
    ptr_m = 0;
    do_txn("after_reset", 4, 0, 1'b1);
    req_m = '0;
    drive();
  endtask

`ifdef ADD_SERIAL_SCHED_WATCHDOG_EN
  task automatic test_watchdog_timeout();
    req_m  = 4'b1000;
    a_m[3] = W'($urandom);
    b_m[3] = W'($urandom);
    drive();
    tick();  // ISSUE
    req_m = '0;
    drive();
    for (int j = 1; j <= TO; j++) tick();  // now in WAIT cycle TO
    checks++;
    if ({rsp_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL wd_early: rsp_valid=%b busy=%b on WAIT cycle %0d, need 0 1", rsp_valid, busy, TO);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_err} !== {1'b1, IDW'(3), {W{1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL wd_timeout: valid=%b id=%0d sum=%h err=%b, need 1 3 00 1",
               rsp_valid, rsp_id, rsp_sum, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL wd_handshake: rsp_valid=%b busy=%b, need 0 0", rsp_valid, busy);
    end
    ptr_m = 0;
  endtask

  task automatic test_watchdog_late_done();
    req_m  = 4'b0001;
    a_m[0] = W'($urandom);
    b_m[0] = W'($urandom);
    drive();
    do_txn("wd_late_done", TO, 1, 1'b1);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req       = '0;
    a_in      = '0;
    b_in      = '0;
    add_done  = 1'b0;
    add_sum   = '0;
    rsp_ready = 1'b0;
    req_m     = '0;
    ptr_m     = 0;
    for (int i = 0; i < N; i++) begin
      a_m[i] = '0;
      b_m[i] = '0;
    end

    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_backpressure();
    test_random();
    test_reset_mid_wait();
`ifdef ADD_SERIAL_SCHED_WATCHDOG_EN
    test_watchdog_timeout();
    test_watchdog_late_done();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, need completion", $time);
    $fatal(1, "time limit reached");
  end

endmodule
